// File: rtl/dds_wave_gen.sv
// Direct digital synthesis waveform generator: 32-bit phase accumulator with
// square/saw/triangle/DC shaping, one sample per two PLL_CLK cycles.
module dds_wave_gen #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned DATA_W  = 10
) (
  input  logic               PLL_CLK,
  input  logic               RESETn,
  input  logic               enable,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  output logic [DATA_W-1:0]  dac_data,
  output logic               sample_stb
);

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state, state_next;
  logic                tick;
  logic [PHASE_W-1:0]  phase, phase_d, phase_sum;
  logic [PHASE_W-1:0]  ftw_active, ftw_active_d;
  logic [PHASE_W-1:0]  ftw_pend, ftw_pend_d;
  logic [DATA_W-1:0]   wave, dac_d;
  logic                stb_d;
  logic                wrap;
  logic                hs;

  // Shaping uses the pre-update phase, giving one sample of latency.
  always_comb begin
    wave = MIDSCALE;
    case (wave_sel)
      2'b00:   wave = phase[PHASE_W-1] ? '1 : '0;
      2'b01:   wave = phase[PHASE_W-1 -: DATA_W];
      2'b10:   wave = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: DATA_W]
                                       :  phase[PHASE_W-2 -: DATA_W];
      default: wave = MIDSCALE;
    endcase
  end

  always_comb begin
    ftw_ready          = (state != PEND);
    hs                 = ftw_valid & ftw_ready;
    {wrap, phase_sum}  = {1'b0, phase} + {1'b0, ftw_active};
    state_next         = state;
    phase_d            = phase;
    ftw_active_d       = ftw_active;
    ftw_pend_d         = ftw_pend;
    dac_d              = dac_data;
    stb_d              = 1'b0;

    case (state)
      STOP: begin
        if (hs)     ftw_active_d = ftw_in;
        if (enable) state_next   = RUN;
      end
      RUN, PEND: begin
        if (!enable) begin
          // A word accepted on the stopping edge is applied immediately, as if
          // it had been buffered and then flushed on STOP entry.
          state_next = STOP;
          phase_d    = '0;
          dac_d      = MIDSCALE;
          if (state == PEND) ftw_active_d = ftw_pend;
          else if (hs)       ftw_active_d = ftw_in;
        end else begin
          if (tick) begin
            phase_d = phase_sum;
            dac_d   = wave;
            stb_d   = 1'b1;
            if (state == PEND && wrap) begin
              ftw_active_d = ftw_pend;
              state_next   = RUN;
            end
          end
          if (state == RUN && hs) begin
            ftw_pend_d = ftw_in;
            state_next = PEND;
          end
        end
      end
      default: state_next = STOP;
    endcase
  end

  always_ff @(posedge PLL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= STOP;
      tick       <= 1'b0;
      phase      <= '0;
      ftw_active <= '0;
      ftw_pend   <= '0;
      dac_data   <= MIDSCALE;
      sample_stb <= 1'b0;
    end else begin
      state      <= state_next;
      tick       <= ~tick;
      phase      <= phase_d;
      ftw_active <= ftw_active_d;
      ftw_pend   <= ftw_pend_d;
      dac_data   <= dac_d;
      sample_stb <= stb_d;
    end
  end

endmodule
